// File: rtl/sodor_iltype_instr_gen.sv
// sodor_iltype_instr_gen
//   Constrained-random RISC-V instruction source for the sodor5_verif imem
//   port. Emits I-type ALU ops (opcode 0010011) and byte loads
//   (opcode 0000011) whose fields come from a 32-bit Galois LFSR, so a given
//   SEED always reproduces the same instruction trace.
//
// Handshake: a word transfers on any rising clk edge where
//   instr_valid && instr_ready. While instr_valid && !instr_ready, instr and
//   all internal state (LFSR, counters, FSM) hold; mode is only sampled when
//   the next candidate is built, i.e. on a transfer.
//
// Ports
//   clk          in   1   clock, all state on posedge
//   reset_n      in   1   asynchronous active-low reset
//   mode         in   2   00 mixed, 01 ALU only, 10 load only, 11 NOP only
//   instr_ready  in   1   consumer accepts instr this cycle
//   instr_valid  out  1   instr is presented
//   instr        out  32  instruction word
//   issued_cnt   out  32  random instrs accepted (NOPs excluded), saturating
//   done         out  1   NUM_INSTR reached; held until reset
//   state_dbg    out  2   FSM state (0 PRELUDE, 1 GEN, 2 DONE)
module sodor_iltype_instr_gen #(
  parameter logic [31:0] SEED        = 32'h0000_0060,
  parameter int unsigned NOP_CYCLES  = 4,
  parameter int unsigned NUM_INSTR   = 0,
  parameter logic [11:0] LD_IMM_MASK = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mode,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] issued_cnt,
  output logic        done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_PRELUDE = 2'd0,
    ST_GEN     = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] TAPS      = 32'h8020_0003;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [31:0] NOP_LIMIT = 32'(NOP_CYCLES);
  localparam logic [32:0] NUM_LIMIT = 33'(NUM_INSTR);

  state_e      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] nop_cnt_q, nop_cnt_d;
  logic        done_q, done_d;

  logic [31:0] lfsr_a, lfsr_b;
  logic [11:0] alu_imm;
  logic [31:0] alu_word, ld_word, cand_word;
  logic        accept;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? TAPS : 32'h0);
  endfunction

  // Next candidate word, built from two consecutive LFSR states.
  always_comb begin
    lfsr_a  = lfsr_step(lfsr_q);
    lfsr_b  = lfsr_step(lfsr_a);
    alu_imm = lfsr_a[31:20];
    // Shift-immediates: keep shamt, and for SRLI/SRAI also the arith bit.
    if (lfsr_a[14:12] == 3'd1) alu_imm = alu_imm & 12'b0000_0001_1111;
    if (lfsr_a[14:12] == 3'd5) alu_imm = alu_imm & 12'b0100_0001_1111;
    alu_word = {alu_imm, lfsr_a[19:15], lfsr_a[14:12], lfsr_a[11:7], 7'b0010011};
    ld_word  = {lfsr_b[31:20] & LD_IMM_MASK, lfsr_a[19:15],
                lfsr_b[14:12] & 3'b100, lfsr_a[11:7], 7'b0000011};
    case (mode)
      2'b00:   cand_word = lfsr_b[0] ? alu_word : ld_word;
      2'b01:   cand_word = alu_word;
      2'b10:   cand_word = ld_word;
      default: cand_word = NOP_WORD;
    endcase
  end

  assign accept = valid_q & instr_ready;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    nop_cnt_d = nop_cnt_q;
    done_d    = done_q;
    case (state_q)
      ST_PRELUDE: begin
        valid_d = 1'b1;
        if (NOP_LIMIT == 32'd0) begin
          state_d = ST_GEN;
          lfsr_d  = lfsr_b;
          instr_d = cand_word;
        end else if (accept) begin
          if (nop_cnt_q == NOP_LIMIT - 32'd1) begin
            state_d = ST_GEN;
            lfsr_d  = lfsr_b;
            instr_d = cand_word;
          end else begin
            nop_cnt_d = nop_cnt_q + 32'd1;
          end
        end
      end
      ST_GEN: begin
        if (accept) begin
          if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
          if (NUM_LIMIT != 33'd0 && ({1'b0, cnt_q} + 33'd1) == NUM_LIMIT) begin
            state_d = ST_DONE;
            instr_d = NOP_WORD;
            done_d  = 1'b1;
          end else begin
            lfsr_d  = lfsr_b;
            instr_d = cand_word;
          end
        end
      end
      ST_DONE: begin
        valid_d = 1'b1;
        instr_d = NOP_WORD;
        done_d  = 1'b1;
      end
      default: state_d = ST_PRELUDE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_PRELUDE;
      lfsr_q    <= SEED_EFF;
      instr_q   <= NOP_WORD;
      valid_q   <= 1'b0;
      cnt_q     <= 32'd0;
      nop_cnt_q <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      nop_cnt_q <= nop_cnt_d;
      done_q    <= done_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign issued_cnt  = cnt_q;
  assign done        = done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_sodor_iltype_instr_gen.sv
module tb_sodor_iltype_instr_gen;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // main instance: default parameters
  logic rst_m, rdy_m; logic [1:0] mode_m;
  logic v_m, d_m; logic [31:0] i_m, c_m; logic [1:0] s_m;
  // SEED=0 and SEED=1 instances share inputs
  logic rst_s, rdy_s; logic [1:0] mode_s;
  logic v_0, d_0, v_1, d_1; logic [31:0] i_0, c_0, i_1, c_1; logic [1:0] s_0, s_1;
  // load-only instance with narrowed immediate mask
  logic rst_l, rdy_l; logic [1:0] mode_l;
  logic v_l, d_l; logic [31:0] i_l, c_l; logic [1:0] s_l;
  // NUM_INSTR=5, NOP_CYCLES=0 instance
  logic rst_n5, rdy_n; logic [1:0] mode_n;
  logic v_n, d_n; logic [31:0] i_n, c_n; logic [1:0] s_n;

  sodor_iltype_instr_gen u_main (
    .clk(clk), .reset_n(rst_m), .mode(mode_m), .instr_ready(rdy_m),
    .instr_valid(v_m), .instr(i_m), .issued_cnt(c_m), .done(d_m), .state_dbg(s_m));

  sodor_iltype_instr_gen #(.SEED(32'h0)) u_s0 (
    .clk(clk), .reset_n(rst_s), .mode(mode_s), .instr_ready(rdy_s),
    .instr_valid(v_0), .instr(i_0), .issued_cnt(c_0), .done(d_0), .state_dbg(s_0));

  sodor_iltype_instr_gen #(.SEED(32'h1)) u_s1 (
    .clk(clk), .reset_n(rst_s), .mode(mode_s), .instr_ready(rdy_s),
    .instr_valid(v_1), .instr(i_1), .issued_cnt(c_1), .done(d_1), .state_dbg(s_1));

  sodor_iltype_instr_gen #(.LD_IMM_MASK(12'h0FF)) u_ld (
    .clk(clk), .reset_n(rst_l), .mode(mode_l), .instr_ready(rdy_l),
    .instr_valid(v_l), .instr(i_l), .issued_cnt(c_l), .done(d_l), .state_dbg(s_l));

  sodor_iltype_instr_gen #(.NOP_CYCLES(0), .NUM_INSTR(5)) u_num (
    .clk(clk), .reset_n(rst_n5), .mode(mode_n), .instr_ready(rdy_n),
    .instr_valid(v_n), .instr(i_n), .issued_cnt(c_n), .done(d_n), .state_dbg(s_n));

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_step(input logic [31:0] x);
    if ((x & 32'h1) != 32'h0) return (x >> 1) ^ 32'h8020_0003;
    return x >> 1;
  endfunction

  // Builds the next word from the current LFSR state and returns the new state.
  task automatic model_gen(input logic [31:0] l_in, input logic [1:0] md,
                           input logic [31:0] mask, output logic [31:0] l_out,
                           output logic [31:0] w);
    logic [31:0] a, b, imm, rs1, rd, f3, alu, limm, lf3, ld;
    a    = ref_step(l_in);
    b    = ref_step(a);
    imm  = (a >> 20) & 32'hFFF;
    rs1  = (a >> 15) & 32'h1F;
    f3   = (a >> 12) & 32'h7;
    rd   = (a >> 7)  & 32'h1F;
    if (f3 == 32'd1) imm = imm & 32'h01F;
    if (f3 == 32'd5) imm = imm & 32'h41F;
    alu  = (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
    limm = (b >> 20) & 32'hFFF & mask;
    lf3  = (b >> 12) & 32'h4;
    ld   = (limm << 20) | (rs1 << 15) | (lf3 << 12) | (rd << 7) | 32'h03;
    case (md)
      2'd0:    w = ((b & 32'h1) != 32'h0) ? alu : ld;
      2'd1:    w = alu;
      2'd2:    w = ld;
      default: w = NOP;
    endcase
    l_out = b;
  endtask

  // main-instance model state, carried across tasks
  logic [31:0] m_lfsr, m_exp, m_words;
  logic [1:0]  m_exp_mode;

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_m = 0; rst_s = 0; rst_l = 0; rst_n5 = 0;
    rdy_m = 0; rdy_s = 0; rdy_l = 0; rdy_n = 0;
    mode_m = 2'b00; mode_s = 2'b00; mode_l = 2'b10; mode_n = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (v_m !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", v_m); end
      n_checks++; if (i_m !== NOP) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", i_m, NOP); end
      n_checks++; if (c_m !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", c_m); end
      n_checks++; if (d_m !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", d_m); end
      n_checks++; if (v_n !== 1'b0 || i_n !== NOP) begin n_fail++; $display("FAIL reset_num got=%b/%h exp=0/%h", v_n, i_n, NOP); end
    end
    rst_m = 1; rst_s = 1; rst_l = 1; rst_n5 = 1;
    m_lfsr = 32'h60; m_words = 0; m_exp = NOP; m_exp_mode = 2'b00;
  endtask

  task automatic test_prelude;
    int nops = 0;
    int cyc  = 0;
    while (m_words < 20 && cyc < 200) begin
      @(negedge clk); cyc++;
      n_checks++; if (v_m !== 1'b1) begin n_fail++; $display("FAIL prelude_valid got=%b exp=1", v_m); end
      n_checks++; if (c_m !== m_words) begin n_fail++; $display("FAIL prelude_cnt got=%0d exp=%0d", c_m, m_words); end
      n_checks++;
      if (nops < 4) begin
        if (i_m !== NOP) begin n_fail++; $display("FAIL prelude_nop got=%h exp=%h", i_m, NOP); end
      end else if (i_m !== m_exp) begin
        n_fail++; $display("FAIL prelude_word got=%h exp=%h", i_m, m_exp);
      end
      rdy_m = 1;
      if (nops < 4) begin
        nops++;
        if (nops == 4) begin model_gen(m_lfsr, mode_m, 32'hFFF, m_lfsr, m_exp); m_exp_mode = mode_m; end
      end else begin
        m_words++;
        model_gen(m_lfsr, mode_m, 32'hFFF, m_lfsr, m_exp); m_exp_mode = mode_m;
      end
    end
    n_checks++; if (m_words != 20) begin n_fail++; $display("FAIL prelude_timeout got=%0d exp=20", m_words); end
    @(negedge clk);
    rdy_m = 0;  // the accept decided above has happened; stop here
    n_checks++; if (i_m !== m_exp) begin n_fail++; $display("FAIL prelude_last got=%h exp=%h", i_m, m_exp); end
  endtask

  task automatic test_alu_only;
    int acc = 0;
    int cyc = 0;
    mode_m = 2'b01;
    while (acc < 1000 && cyc < 5000) begin
      @(negedge clk); cyc++;
      n_checks++; if (i_m !== m_exp) begin n_fail++; $display("FAIL alu_word got=%h exp=%h", i_m, m_exp); end
      n_checks++; if (c_m !== m_words) begin n_fail++; $display("FAIL alu_cnt got=%0d exp=%0d", c_m, m_words); end
      rdy_m = ($urandom_range(0, 3) != 0);
      if (rdy_m && v_m) begin
        if (m_exp_mode == 2'b01) begin
          n_checks++; if (i_m[6:0] !== 7'b0010011) begin n_fail++; $display("FAIL alu_opcode got=%b exp=0010011", i_m[6:0]); end
          if (i_m[14:12] == 3'd1) begin
            n_checks++; if (i_m[31:25] !== 7'd0) begin n_fail++; $display("FAIL alu_slli got=%b exp=0000000", i_m[31:25]); end
          end
          if (i_m[14:12] == 3'd5) begin
            n_checks++; if (i_m[31:25] !== 7'd0 && i_m[31:25] !== 7'b0100000) begin n_fail++; $display("FAIL alu_sri got=%b exp=0000000|0100000", i_m[31:25]); end
          end
          acc++;
        end
        m_words++;
        model_gen(m_lfsr, mode_m, 32'hFFF, m_lfsr, m_exp); m_exp_mode = mode_m;
      end
    end
    n_checks++; if (acc != 1000) begin n_fail++; $display("FAIL alu_timeout got=%0d exp=1000", acc); end
    @(negedge clk);
    rdy_m = 0;
    mode_m = 2'b00;
  endtask

  task automatic test_stall;
    logic [31:0] prev_i, prev_c;
    logic prev_acc = 1'b1;
    prev_i = i_m; prev_c = c_m;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_checks++; if (i_m !== m_exp) begin n_fail++; $display("FAIL stall_word got=%h exp=%h", i_m, m_exp); end
      n_checks++; if (c_m !== m_words) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=%0d", c_m, m_words); end
      if (!prev_acc) begin
        n_checks++; if (i_m !== prev_i || c_m !== prev_c) begin n_fail++; $display("FAIL stall_frozen got=%h/%0d exp=%h/%0d", i_m, c_m, prev_i, prev_c); end
      end
      prev_i = i_m; prev_c = c_m;
      rdy_m = (k % 4 == 0) || (k % 4 == 3);
      prev_acc = rdy_m;
      if (rdy_m) begin
        m_words++;
        model_gen(m_lfsr, mode_m, 32'hFFF, m_lfsr, m_exp); m_exp_mode = mode_m;
      end
    end
    @(negedge clk);
    rdy_m = 0;
  endtask

  task automatic test_load_only;
    logic [31:0] l_lfsr, l_exp, l_words;
    int nops = 0;
    int cyc  = 0;
    l_lfsr = 32'h60; l_exp = NOP; l_words = 0;
    while (l_words < 1000 && cyc < 5000) begin
      @(negedge clk); cyc++;
      n_checks++; if (c_l !== l_words) begin n_fail++; $display("FAIL ld_cnt got=%0d exp=%0d", c_l, l_words); end
      n_checks++; if (i_l !== ((nops < 4) ? NOP : l_exp)) begin n_fail++; $display("FAIL ld_word got=%h exp=%h", i_l, (nops < 4) ? NOP : l_exp); end
      rdy_l = ($urandom_range(0, 2) != 0);
      if (rdy_l && v_l) begin
        if (nops < 4) begin
          nops++;
          if (nops == 4) model_gen(l_lfsr, 2'b10, 32'h0FF, l_lfsr, l_exp);
        end else begin
          n_checks++; if (i_l[6:0] !== 7'b0000011) begin n_fail++; $display("FAIL ld_opcode got=%b exp=0000011", i_l[6:0]); end
          n_checks++; if (i_l[14:12] !== 3'd0 && i_l[14:12] !== 3'd4) begin n_fail++; $display("FAIL ld_f3 got=%0d exp=0|4", i_l[14:12]); end
          n_checks++; if (i_l[31:28] !== 4'd0) begin n_fail++; $display("FAIL ld_immmask got=%h exp=0", i_l[31:28]); end
          l_words++;
          model_gen(l_lfsr, 2'b10, 32'h0FF, l_lfsr, l_exp);
        end
      end
    end
    n_checks++; if (l_words != 1000) begin n_fail++; $display("FAIL ld_timeout got=%0d exp=1000", l_words); end
    @(negedge clk);
    rdy_l = 0;
  endtask

  task automatic test_seed_zero;
    logic [31:0] z_lfsr, z_exp, z_words;
    int nops = 0;
    int cyc  = 0;
    z_lfsr = 32'h1; z_exp = NOP; z_words = 0;
    while (z_words < 200 && cyc < 1000) begin
      @(negedge clk); cyc++;
      n_checks++; if (i_0 !== i_1 || c_0 !== c_1 || v_0 !== v_1) begin n_fail++; $display("FAIL seed_match got=%h/%0d exp=%h/%0d", i_0, c_0, i_1, c_1); end
      n_checks++; if (i_0 !== ((nops < 4) ? NOP : z_exp)) begin n_fail++; $display("FAIL seed_word got=%h exp=%h", i_0, (nops < 4) ? NOP : z_exp); end
      rdy_s = $urandom_range(0, 1) != 0;
      if (rdy_s && v_0) begin
        if (nops < 4) begin
          nops++;
          if (nops == 4) model_gen(z_lfsr, 2'b00, 32'hFFF, z_lfsr, z_exp);
        end else begin
          z_words++;
          model_gen(z_lfsr, 2'b00, 32'hFFF, z_lfsr, z_exp);
        end
      end
    end
    n_checks++; if (z_words != 200) begin n_fail++; $display("FAIL seed_timeout got=%0d exp=200", z_words); end
    @(negedge clk);
    rdy_s = 0;
  endtask

  task automatic test_num_instr;
    logic [31:0] n_lfsr, n_exp, n_words;
    int cyc = 0;
    int post = 0;
    // NOP_CYCLES=0: the first random word is already up after release.
    n_lfsr = 32'h60; n_words = 0;
    model_gen(n_lfsr, 2'b00, 32'hFFF, n_lfsr, n_exp);
    while (n_words < 3 && cyc < 100) begin
      @(negedge clk); cyc++;
      n_checks++; if (v_n !== 1'b1 || i_n !== n_exp) begin n_fail++; $display("FAIL num_word1 got=%b/%h exp=1/%h", v_n, i_n, n_exp); end
      n_checks++; if (c_n !== n_words || d_n !== 1'b0) begin n_fail++; $display("FAIL num_cnt1 got=%0d/%b exp=%0d/0", c_n, d_n, n_words); end
      rdy_n = 1;
      n_words++;
      model_gen(n_lfsr, 2'b00, 32'hFFF, n_lfsr, n_exp);
    end
    // Pulse reset right after accept #3.
    @(posedge clk); #2;
    rst_n5 = 0; #1;
    n_checks++; if (v_n !== 1'b0 || i_n !== NOP || c_n !== 32'd0 || d_n !== 1'b0) begin
      n_fail++; $display("FAIL num_async_reset got=%b/%h/%0d/%b exp=0/%h/0/0", v_n, i_n, c_n, d_n, NOP);
    end
    @(negedge clk); rdy_n = 0;
    @(negedge clk); rst_n5 = 1;
    n_lfsr = 32'h60; n_words = 0;
    model_gen(n_lfsr, 2'b00, 32'hFFF, n_lfsr, n_exp);
    cyc = 0;
    while (post < 10 && cyc < 300) begin
      @(negedge clk); cyc++;
      n_checks++; if (v_n !== 1'b1) begin n_fail++; $display("FAIL num_valid got=%b exp=1", v_n); end
      n_checks++; if (c_n !== n_words) begin n_fail++; $display("FAIL num_cnt got=%0d exp=%0d", c_n, n_words); end
      n_checks++; if (d_n !== (n_words == 5)) begin n_fail++; $display("FAIL num_done got=%b exp=%b", d_n, n_words == 5); end
      n_checks++; if (i_n !== ((n_words == 5) ? NOP : n_exp)) begin n_fail++; $display("FAIL num_word got=%h exp=%h", i_n, (n_words == 5) ? NOP : n_exp); end
      if (n_words == 5) post++;
      rdy_n = $urandom_range(0, 1) != 0;
      if (rdy_n && n_words < 5) begin
        n_words++;
        if (n_words < 5) model_gen(n_lfsr, 2'b00, 32'hFFF, n_lfsr, n_exp);
      end
    end
    n_checks++; if (post != 10) begin n_fail++; $display("FAIL num_timeout got=%0d exp=10", post); end
    rdy_n = 0;
  endtask

  initial begin
    test_reset();
    test_prelude();
    test_alu_only();
    test_stall();
    test_load_only();
    test_seed_zero();
    test_num_instr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
